pipeline_hazard_ctrl: RTL
=========================

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 Parameter MUL_LATENCY, default 3, cycles EX occupancy for MUL/MULH/MULHSU/MULHU.
REQ-002 Parameter DIV_LATENCY, default 33, cycles EX occupancy for DIV/DIVU/REM/REMU.
REQ-003 CLK  in  1  single clock, all state updates on rising edge.
REQ-004 RESET  in  1  asynchronous, active-low reset.
REQ-005 IMEM_BUSYWAIT  in  1  instruction memory not ready.
REQ-006 DMEM_BUSYWAIT  in  1  data memory not ready.
REQ-007 ID_RS1, ID_RS2  in  5 each  source registers of the instruction in ID.
REQ-008 EX_RD  in  5  destination register of the instruction in EX.
REQ-009 EX_MEM_READ  in  1  instruction in EX is a load.
REQ-010 EX_BRANCH_TAKEN  in  1  jump or taken branch resolved in EX.
REQ-011 EX_MULDIV_START  in  1  M-extension instruction entering EX this cycle.
REQ-012 EX_MULDIV_IS_DIV  in  1  qualifies START: 1 = divide/remainder, 0 = multiply.
REQ-013 PC_HOLD, IF_ID_HOLD, ID_EX_HOLD, EX_MEM_HOLD, MEM_WB_HOLD  out  1 each  BUSYWAIT drive to the PC and each pipeline register.
REQ-014 IF_ID_FLUSH, ID_EX_FLUSH, EX_MEM_FLUSH  out  1 each  load zeros (bubble) into that register at the next edge.
REQ-015 MULDIV_DONE  out  1  one-cycle pulse when the M-unit result is valid.
REQ-016 MULDIV_BUSY  out  1  high while in state MULDIV_WAIT.

Function
REQ-017 Freeze = IMEM_BUSYWAIT or DMEM_BUSYWAIT; while freeze is high, all five HOLD outputs are 1, all FLUSH outputs are 0, and state and counter are unchanged.
REQ-018 FSM states: RUN and MULDIV_WAIT; the 6-bit down-counter CNT is valid only in MULDIV_WAIT.
REQ-019 RUN, no freeze, EX_MULDIV_START=1: next state MULDIV_WAIT, CNT loaded with (IS_DIV ? DIV_LATENCY : MUL_LATENCY) - 1.
REQ-020 MULDIV_WAIT, no freeze: PC_HOLD, IF_ID_HOLD and ID_EX_HOLD are 1; EX_MEM_FLUSH is 1; MEM_WB_HOLD and EX_MEM_HOLD are 0; CNT decrements by 1.
REQ-021 MULDIV_WAIT with CNT=0 and no freeze: MULDIV_DONE=1, all holds and flushes 0, next state RUN.
REQ-022 Total M-instruction EX occupancy equals its latency parameter plus cycles spent frozen; latency 1 means DONE in the cycle after the START edge.
REQ-023 Load-use in RUN: if EX_MEM_READ, EX_RD != 0 and EX_RD equals ID_RS1 or ID_RS2, then PC_HOLD=1, IF_ID_HOLD=1, ID_EX_FLUSH=1 for exactly that cycle.
REQ-024 Branch in RUN: EX_BRANCH_TAKEN=1 gives IF_ID_FLUSH=1 and ID_EX_FLUSH=1; PC_HOLD=0 so the target loads.
REQ-025 Priority: freeze, then MULDIV_WAIT, then branch, then load-use, then start; a branch suppresses a simultaneous load-use stall; EX_BRANCH_TAKEN is ignored in MULDIV_WAIT.
REQ-026 EX_MULDIV_START asserted together with EX_BRANCH_TAKEN is ignored; the state stays RUN.
REQ-027 EX_MULDIV_START asserted while already in MULDIV_WAIT is ignored.
REQ-028 HOLD and FLUSH outputs are combinational from state, CNT and inputs; MULDIV_DONE and MULDIV_BUSY decode from state and CNT only.
REQ-029 In RUN with no hazard, every output is 0.

Reset
REQ-030 RESET low asynchronously forces state RUN and CNT=0.
REQ-031 While RESET is low, all outputs are 0 regardless of inputs.
REQ-032 Reset asserted mid-MULDIV_WAIT abandons the operation and produces no DONE pulse.
REQ-033 After release, the first rising edge evaluates normally.

Structure
REQ-034 The shared macros file holds the state encodings (RUN=1'b0, MULDIV_WAIT=1'b1) and the default latency constants.
REQ-035 Sub-module muldiv_latency_counter holds the loadable, enable-gated 6-bit down-counter with a zero flag.
REQ-036 The FSM and the hazard decode stay in pipeline_hazard_ctrl.

Verification
REQ-037 Reset: RESET=0 at t=1 with DMEM_BUSYWAIT=1 and EX_MULDIV_START=1 -> all outputs 0, MULDIV_BUSY=0.
REQ-038 Load-use: EX_MEM_READ=1, EX_RD=5, ID_RS2=5 -> PC_HOLD=IF_ID_HOLD=ID_EX_FLUSH=1 for one cycle; the same stimulus with EX_RD=0 -> no stall.
REQ-039 DIV: START with IS_DIV=1 -> BUSY high 33 cycles, MULDIV_DONE pulses in the 33rd cycle, EX_MEM_FLUSH high for the first 32; MUL -> DONE in the 3rd cycle.
REQ-040 Freeze mid-DIV: DMEM_BUSYWAIT=1 for 4 cycles after cycle 10 -> all holds 1 and DONE delayed to cycle 37.
REQ-041 Branch with load-use: EX_BRANCH_TAKEN=1 and a matching load-use together -> IF_ID_FLUSH=ID_EX_FLUSH=1, PC_HOLD=0.
REQ-042 Reset mid-MUL: RESET low in cycle 2 -> no DONE pulse and state RUN after release.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM encodings,
// counter width and the default M-extension latencies.
package pipeline_hazard_ctrl_pkg;

  typedef enum logic {
    ST_RUN         = 1'b0,
    ST_MULDIV_WAIT = 1'b1
  } state_e;

  localparam int CNT_W           = 6;
  localparam int DEF_MUL_LATENCY = 3;
  localparam int DEF_DIV_LATENCY = 33;

endpackage

// File: rtl/pipeline_hazard_ctrl_muldiv_latency_counter.sv
// Loadable, enable-gated 6-bit down-counter with zero flag.
// Load wins over enable; reset clears the count.
module muldiv_latency_counter
  import pipeline_hazard_ctrl_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_en,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_zero
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_cnt  = r_cnt;
  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: memory freeze, multi-cycle MUL/DIV stall,
// branch flush and load-use stall for a 5-stage pipeline.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int MUL_LATENCY = DEF_MUL_LATENCY,
  parameter int DIV_LATENCY = DEF_DIV_LATENCY
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_imem_busywait,
  input  logic       i_dmem_busywait,
  input  logic [4:0] i_id_rs1,
  input  logic [4:0] i_id_rs2,
  input  logic [4:0] i_ex_rd,
  input  logic       i_ex_mem_read,
  input  logic       i_ex_branch_taken,
  input  logic       i_ex_muldiv_start,
  input  logic       i_ex_muldiv_is_div,
  output logic       o_pc_hold,
  output logic       o_if_id_hold,
  output logic       o_id_ex_hold,
  output logic       o_ex_mem_hold,
  output logic       o_mem_wb_hold,
  output logic       o_if_id_flush,
  output logic       o_id_ex_flush,
  output logic       o_ex_mem_flush,
  output logic       o_muldiv_done,
  output logic       o_muldiv_busy
);

  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LATENCY - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LATENCY - 1);

  state_e           r_state;
  state_e           w_state_nxt;
  logic             w_freeze;
  logic             w_load_use;
  logic             w_cnt_load;
  logic             w_cnt_en;
  logic [CNT_W-1:0] w_cnt_load_val;
  logic [CNT_W-1:0] w_cnt;
  logic             w_cnt_zero;

  assign w_freeze   = i_imem_busywait | i_dmem_busywait;
  assign w_load_use = i_ex_mem_read && (i_ex_rd != 5'd0) &&
                      ((i_ex_rd == i_id_rs1) || (i_ex_rd == i_id_rs2));
  assign w_cnt_load_val = i_ex_muldiv_is_div ? DIV_LOAD : MUL_LOAD;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_load     = 1'b0;
    w_cnt_en       = 1'b0;
    o_pc_hold      = 1'b0;
    o_if_id_hold   = 1'b0;
    o_id_ex_hold   = 1'b0;
    o_ex_mem_hold  = 1'b0;
    o_mem_wb_hold  = 1'b0;
    o_if_id_flush  = 1'b0;
    o_id_ex_flush  = 1'b0;
    o_ex_mem_flush = 1'b0;
    // Outputs are gated by reset so the pipeline sees no stall while held in reset.
    if (!i_rst_n) begin
      w_state_nxt = ST_RUN;
    end else if (w_freeze) begin
      o_pc_hold     = 1'b1;
      o_if_id_hold  = 1'b1;
      o_id_ex_hold  = 1'b1;
      o_ex_mem_hold = 1'b1;
      o_mem_wb_hold = 1'b1;
    end else if (r_state == ST_MULDIV_WAIT) begin
      if (w_cnt_zero) begin
        w_state_nxt = ST_RUN;
      end else begin
        // Keep the M-instruction in EX and feed bubbles downstream.
        o_pc_hold      = 1'b1;
        o_if_id_hold   = 1'b1;
        o_id_ex_hold   = 1'b1;
        o_ex_mem_flush = 1'b1;
        w_cnt_en       = 1'b1;
      end
    end else if (i_ex_branch_taken) begin
      o_if_id_flush = 1'b1;
      o_id_ex_flush = 1'b1;
    end else if (w_load_use) begin
      o_pc_hold     = 1'b1;
      o_if_id_hold  = 1'b1;
      o_id_ex_flush = 1'b1;
    end else if (i_ex_muldiv_start) begin
      w_state_nxt = ST_MULDIV_WAIT;
      w_cnt_load  = 1'b1;
    end
  end

  // DONE/BUSY depend only on state and count; a freeze at count zero extends DONE.
  assign o_muldiv_busy = i_rst_n && (r_state == ST_MULDIV_WAIT);
  assign o_muldiv_done = o_muldiv_busy && w_cnt_zero;

  muldiv_latency_counter u_cnt (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_load     (w_cnt_load),
    .i_load_val (w_cnt_load_val),
    .i_en       (w_cnt_en),
    .o_cnt      (w_cnt),
    .o_zero     (w_cnt_zero)
  );

endmodule
